// File: rtl/freq_meter.sv
// ---------------------------------------------------------------------------
// freq_meter
//
// Counts rising edges of an asynchronous input over a fixed gate of
// GATE_CYCLES clock cycles and publishes the count at the end of each gate.
// With EN held high, gates run back to back with one dead cycle between them.
//
// Parameters
//   GATE_CYCLES : gate length in CLK cycles (2 .. 2^32-1)
//   FREQ_W      : width of the FREQ result
//
// Ports
//   CLK   in   sole clock, rising edge
//   RST_N in   synchronous active-low reset
//   SIGIN in   asynchronous signal to be measured
//   EN    in   1 = measure continuously, 0 = stop / abort current gate
//   FREQ  out  rising edges counted in the last completed gate
//   VALID out  one-cycle pulse while the freshly updated FREQ is presented
//   BUSY  out  high while a gate is in progress
//   OVF   out  (only with FREQ_METER_OVF_EN) edge count saturated in the
//              gate reported by FREQ
//
// Build option
//   FREQ_METER_OVF_EN : adds the OVF output and its tracking logic.
// ---------------------------------------------------------------------------
module freq_meter #(
    parameter int unsigned GATE_CYCLES = 50000000,
    parameter int          FREQ_W      = 26
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              SIGIN,
    input  logic              EN,
    output logic [FREQ_W-1:0] FREQ,
    output logic              VALID,
`ifdef FREQ_METER_OVF_EN
    output logic              BUSY,
    output logic              OVF
`else
    output logic              BUSY
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0]       LAST_CYCLE = 32'(GATE_CYCLES - 1);
    localparam logic [FREQ_W-1:0] COUNT_MAX  = {FREQ_W{1'b1}};

    state_t            state;
    state_t            state_next;
    logic              sync_1;
    logic              sync_2;
    logic              prev;
    logic              edge_det;
    logic [31:0]       gate_cnt;
    logic [FREQ_W-1:0] edge_cnt;
    logic [FREQ_W-1:0] edge_cnt_next;
    logic              last_cycle;
`ifdef FREQ_METER_OVF_EN
    logic              ovf_seen;
    logic              ovf_seen_next;
`endif

    // A SIGIN edge shows up on edge_det two cycles after it is sampled and
    // lands in the counter on the third, giving the 3-cycle detection latency.
    assign edge_det   = sync_2 & ~prev;
    assign last_cycle = (gate_cnt == LAST_CYCLE);

    assign BUSY  = (state == GATE);
    assign VALID = (state == DONE);

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Dropping EN in the middle of a gate abandons it.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (EN) begin
                    state_next = GATE;
                end
            end
            GATE: begin
                if (!EN) begin
                    state_next = IDLE;
                end else if (last_cycle) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = EN ? GATE : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Saturating edge count including the current cycle's edge, so that an
    // edge on the final gate cycle still makes it into the published result.
    always_comb begin
        edge_cnt_next = edge_cnt;
`ifdef FREQ_METER_OVF_EN
        ovf_seen_next = ovf_seen;
`endif
        if (edge_det) begin
            if (edge_cnt == COUNT_MAX) begin
`ifdef FREQ_METER_OVF_EN
                ovf_seen_next = 1'b1;
`endif
            end else begin
                edge_cnt_next = edge_cnt + 1'b1;
            end
        end
    end

    // Datapath. FREQ is loaded on the last gate cycle so that the new value
    // is already on the output during the DONE cycle when VALID is high.
    // Counters are held clear outside GATE, which gives every gate a clean
    // start and discards edges seen in IDLE or DONE.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sync_1   <= 1'b0;
            sync_2   <= 1'b0;
            prev     <= 1'b0;
            gate_cnt <= '0;
            edge_cnt <= '0;
            FREQ     <= '0;
`ifdef FREQ_METER_OVF_EN
            ovf_seen <= 1'b0;
            OVF      <= 1'b0;
`endif
        end else begin
            sync_1 <= SIGIN;
            sync_2 <= sync_1;
            prev   <= sync_2;
            if (state == GATE) begin
                gate_cnt <= gate_cnt + 32'd1;
                edge_cnt <= edge_cnt_next;
`ifdef FREQ_METER_OVF_EN
                ovf_seen <= ovf_seen_next;
`endif
                if (EN && last_cycle) begin
                    FREQ <= edge_cnt_next;
`ifdef FREQ_METER_OVF_EN
                    OVF  <= ovf_seen_next;
`endif
                end
            end else begin
                gate_cnt <= '0;
                edge_cnt <= '0;
`ifdef FREQ_METER_OVF_EN
                ovf_seen <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 50000000: gate length in CLK cycles (1 s at 50 MHz); legal range 2 to 2^32-1.
REQ-002 SHALL have parameter FREQ_W, default 26: width of FREQ, matching the 26-bit Freq input of the team's dynamic sub-clock generator.
REQ-003 SHALL have port CLK  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port RST_N  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port SIGIN  input  1  asynchronous signal to be measured.
REQ-006 SHALL have port EN  input  1  level; 1 = measure continuously, 0 = stop.
REQ-007 SHALL have port FREQ  output  FREQ_W  rising edges counted in the last completed gate (Hz when the gate is 1 s).
REQ-008 SHALL have port VALID  output  1  one-cycle pulse when FREQ is updated.
REQ-009 SHALL have port BUSY  output  1  high while a gate is in progress.

Function
REQ-010 SHALL pass SIGIN through a 2-flop synchronizer, then a previous-sample flop; edge = sync_out & ~prev.
REQ-011 SHALL implement states IDLE, GATE, DONE; BUSY = (state == GATE).
REQ-012 IDLE: SHALL stay while EN=0; on EN=1, SHALL enter GATE next cycle with gate counter = 0 and edge count = 0.
REQ-013 GATE: SHALL increment a 32-bit gate counter every cycle and increment the edge count on every edge cycle.
REQ-014 SHALL count an edge that occurs on the final gate cycle (counter == GATE_CYCLES-1).
REQ-015 SHALL ignore edges detected in IDLE or DONE.
REQ-016 On counter == GATE_CYCLES-1 with EN=1, SHALL enter DONE next cycle.
REQ-017 DONE (one cycle): SHALL load FREQ with the edge count and assert VALID for exactly this cycle.
REQ-018 DONE: SHALL enter GATE with cleared counters if EN=1 (back-to-back gates, one dead cycle between them); otherwise SHALL enter IDLE.
REQ-019 EN=0 during GATE SHALL abort to IDLE next cycle: no VALID, FREQ unchanged, partial count discarded.
REQ-020 Edge count SHALL saturate at 2^FREQ_W-1 and never wrap.
REQ-021 FREQ SHALL hold its value between VALID pulses.
REQ-022 Rate limit: SIGIN high and low phases SHALL each last at least 2 CLK periods for exact counting; faster input is undefined.
REQ-023 Detection latency of a SIGIN edge to the count increment SHALL be 3 CLK cycles; edges within the last 3 cycles before GATE entry are not counted.

Reset
REQ-024 With RST_N=0 on a CLK edge: state=IDLE, FREQ=0, VALID=0, BUSY=0, counters=0, synchronizer and prev flops=0.
REQ-025 Reset during GATE or DONE SHALL discard the measurement without a VALID pulse.
REQ-026 The first GATE after reset release SHALL start no earlier than the cycle after RST_N is sampled high with EN=1.

Configuration
REQ-027 Macro FREQ_METER_OVF_EN, when defined, SHALL add output OVF (1 bit), registered and updated with FREQ in DONE: 1 if the edge count saturated during that gate, else 0; reset value 0; unchanged on abort.
REQ-028 Without FREQ_METER_OVF_EN, the OVF port and its logic SHALL be absent; saturation per REQ-020 still applies.

Verification
REQ-029 GATE_CYCLES=100, SIGIN period 10 CLK (5 high/5 low), EN=1 held -> first VALID 101 cycles after GATE entry, FREQ=10; next VALID 101 cycles later, FREQ=10.
REQ-030 GATE_CYCLES=100, SIGIN period 4 CLK, EN dropped at gate cycle 50 -> no VALID, BUSY=0 next cycle, FREQ keeps its previous value (0 after reset).
REQ-031 GATE_CYCLES=100, SIGIN held 1 (also held 0) -> VALID pulse, FREQ=0.
REQ-032 GATE_CYCLES=100, SIGIN period 4 CLK -> FREQ=25; then change to period 20 CLK -> next full gate reports FREQ=5.
REQ-033 RST_N=0 at gate cycle 60 -> next cycle FREQ=0, VALID=0, BUSY=0; after RST_N=1 with EN=1 a fresh 100-cycle gate completes with correct count.
REQ-034 FREQ_W=4, GATE_CYCLES=100, SIGIN period 4 CLK, FREQ_METER_OVF_EN defined -> FREQ=15, OVF=1 with VALID; period 20 CLK -> FREQ=5, OVF=0.
